// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the ID-stage hazard/stall unit: FSM state encoding,
// the hard-wired zero register, the default register-address width, the MDU
// countdown width and the bundle of pipeline control outputs.
package hazard_stall_unit_pkg;

    localparam int RA_W_DEF  = 5;
    // Four bits cover the legal MDU_LATENCY range of 2..15.
    localparam int MDU_CNT_W = 4;

    localparam logic [0:0] HZ_RUN      = 1'b0;
    localparam logic [0:0] HZ_MDU_BUSY = 1'b1;

    localparam logic [RA_W_DEF-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic ifid_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0, ifid_flush: 1'b0};
    localparam hz_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1, ifid_flush: 1'b0};
    localparam hz_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b1, ifid_flush: 1'b1};

endpackage

// File: rtl/hazard_stall_unit_mdu_busy_timer.sv
// mdu_busy_timer: tracks an in-flight mult/div. A start loads MDU_LATENCY-1
// and the flag stays high until the count runs out, so a HI/LO reader in ID
// is held exactly until the MDU result is forwardable.
module mdu_busy_timer
    import hazard_stall_unit_pkg::*;
#(
    parameter int MDU_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [MDU_CNT_W-1:0] CNT_LOAD = MDU_CNT_W'(MDU_LATENCY - 1);

    logic [0:0]           state_q, state_d;
    logic [MDU_CNT_W-1:0] cnt_q, cnt_d;

    // Next-state logic: load on start, count down while busy, drop out at 1.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HZ_RUN: begin
                if (start) begin
                    state_d = HZ_MDU_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            HZ_MDU_BUSY: begin
                if (start) begin
                    // Illegal while busy (the reader is held), but recover by
                    // restarting the count for the newly issued op.
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == MDU_CNT_W'(1)) begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - MDU_CNT_W'(1);
                end
            end
            default: begin
                state_d = HZ_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers; reset discards any in-flight count.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == HZ_MDU_BUSY);

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: ID-stage hazard control for the hazards forwarding cannot
// cover: load-use (one bubble), HI/LO readers behind a busy MDU, and taken
// branch flushes. Outputs are Mealy (registered MDU state + current inputs).
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int MDU_LATENCY = 4,
    parameter int RA_W        = RA_W_DEF
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W     = 32
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] IFID_Rs,
    input  logic [RA_W-1:0] IFID_Rt,
    input  logic            IFID_UsesRt,
    input  logic            IFID_ReadsHiLo,
    input  logic            IDEX_MemRead,
    input  logic [RA_W-1:0] IDEX_Rt,
    input  logic            IDEX_MduStart,
    input  logic            branch_taken,
    output logic            PCWrite,
    output logic            IFIDWrite,
    output logic            IDEX_Bubble,
    output logic            IFID_Flush,
    output logic            mdu_busy
`ifdef HAZ_PERF_CNT_EN
    , output logic [CNT_W-1:0] load_stall_cnt
    , output logic [CNT_W-1:0] mdu_stall_cnt
    , output logic [CNT_W-1:0] flush_cnt
`endif
);

    logic     load_use;
    logic     mdu_hold;
    hz_ctrl_t ctrl;

    mdu_busy_timer #(
        .MDU_LATENCY (MDU_LATENCY)
    ) u_mdu_busy_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (IDEX_MduStart),
        .busy  (mdu_busy)
    );

    // $0 is hard-wired, so a load targeting it can never create a hazard.
    assign load_use = IDEX_MemRead && (IDEX_Rt != RA_W'(REG_ZERO)) &&
                      ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    assign mdu_hold = mdu_busy && IFID_ReadsHiLo;

    // Priority mux: a taken branch discards the wrong-path stall request.
    always_comb begin
        ctrl = CTRL_NORMAL;
        if (branch_taken) begin
            ctrl = CTRL_FLUSH;
        end else if (load_use || mdu_hold) begin
            ctrl = CTRL_STALL;
        end
    end

    assign PCWrite     = ctrl.pc_write;
    assign IFIDWrite   = ctrl.ifid_write;
    assign IDEX_Bubble = ctrl.idex_bubble;
    assign IFID_Flush  = ctrl.ifid_flush;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] load_stall_cnt_q, load_stall_cnt_d;
    logic [CNT_W-1:0] mdu_stall_cnt_q, mdu_stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters, each bumped when its priority case owns the outputs.
    always_comb begin
        load_stall_cnt_d = load_stall_cnt_q;
        mdu_stall_cnt_d  = mdu_stall_cnt_q;
        flush_cnt_d      = flush_cnt_q;
        if (branch_taken) begin
            if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else begin
            if (load_use && (load_stall_cnt_q != '1)) load_stall_cnt_d = load_stall_cnt_q + CNT_W'(1);
            if (mdu_hold && (mdu_stall_cnt_q != '1))  mdu_stall_cnt_d  = mdu_stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_stall_cnt_q <= '0;
            mdu_stall_cnt_q  <= '0;
            flush_cnt_q      <= '0;
        end else begin
            load_stall_cnt_q <= load_stall_cnt_d;
            mdu_stall_cnt_q  <= mdu_stall_cnt_d;
            flush_cnt_q      <= flush_cnt_d;
        end
    end

    assign load_stall_cnt = load_stall_cnt_q;
    assign mdu_stall_cnt  = mdu_stall_cnt_q;
    assign flush_cnt      = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit (MDU_LATENCY=4). Each scenario pushes
// the expected {PCWrite,IFIDWrite,IDEX_Bubble,IFID_Flush,mdu_busy} when it
// drives a cycle and pops/compares it mid-cycle. Counter checks run only when
// HAZ_PERF_CNT_EN is defined.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IFID_Rs = '0, IFID_Rt = '0, IDEX_Rt = '0;
    logic       IFID_UsesRt = 1'b0, IFID_ReadsHiLo = 1'b0, IDEX_MemRead = 1'b0;
    logic       IDEX_MduStart = 1'b0, branch_taken = 1'b0;
    logic       PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, mdu_busy;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] load_stall_cnt, mdu_stall_cnt, flush_cnt;
    logic [1:0]  sat_load_cnt, sat_mdu_cnt, sat_flush_cnt;
    logic        sat_pcw, sat_ifw, sat_bub, sat_fl, sat_busy;
`endif

    always #5 clk = ~clk;

    hazard_stall_unit #(.MDU_LATENCY(4), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_ReadsHiLo(IFID_ReadsHiLo), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt), .IDEX_MduStart(IDEX_MduStart), .branch_taken(branch_taken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_Bubble(IDEX_Bubble),
        .IFID_Flush(IFID_Flush), .mdu_busy(mdu_busy)
`ifdef HAZ_PERF_CNT_EN
        , .load_stall_cnt(load_stall_cnt), .mdu_stall_cnt(mdu_stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

`ifdef HAZ_PERF_CNT_EN
    hazard_stall_unit #(.MDU_LATENCY(4), .RA_W(5), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_UsesRt(IFID_UsesRt),
        .IFID_ReadsHiLo(IFID_ReadsHiLo), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt), .IDEX_MduStart(IDEX_MduStart), .branch_taken(branch_taken),
        .PCWrite(sat_pcw), .IFIDWrite(sat_ifw), .IDEX_Bubble(sat_bub),
        .IFID_Flush(sat_fl), .mdu_busy(sat_busy),
        .load_stall_cnt(sat_load_cnt), .mdu_stall_cnt(sat_mdu_cnt), .flush_cnt(sat_flush_cnt)
    );
`endif

    // Expected output vectors {PCWrite,IFIDWrite,IDEX_Bubble,IFID_Flush,mdu_busy}.
    localparam logic [4:0] NRM = 5'b11000;
    localparam logic [4:0] STL = 5'b00100;
    localparam logic [4:0] FLS = 5'b11110;
    localparam logic [4:0] BSY = 5'b00001;

    typedef struct {
        logic [4:0] rs, rt, ex_rt;
        logic       uses_rt, hilo, memrd, mdu, br;
        logic [4:0] exp;
    } stim_t;

    wire [4:0] got = {PCWrite, IFIDWrite, IDEX_Bubble, IFID_Flush, mdu_busy};

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [4:0] exp_q[$];

    function automatic stim_t mk(input int rs, input int rt, input int uses_rt, input int hilo,
                                 input int memrd, input int ex_rt, input int mdu, input int br,
                                 input logic [4:0] exp);
        stim_t s;
        s.rs = 5'(rs);       s.rt = 5'(rt);       s.uses_rt = 1'(uses_rt);
        s.hilo = 1'(hilo);   s.memrd = 1'(memrd); s.ex_rt = 5'(ex_rt);
        s.mdu = 1'(mdu);     s.br = 1'(br);       s.exp = exp;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        IFID_Rs = s.rs;          IFID_Rt = s.rt;         IFID_UsesRt = s.uses_rt;
        IFID_ReadsHiLo = s.hilo; IDEX_MemRead = s.memrd; IDEX_Rt = s.ex_rt;
        IDEX_MduStart = s.mdu;   branch_taken = s.br;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        logic [4:0] want;
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, NRM));
        #1;
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", got, want);
        end
`ifdef HAZ_PERF_CNT_EN
        n_tests++;
        if ({load_stall_cnt, mdu_stall_cnt, flush_cnt} !== 96'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", load_stall_cnt, mdu_stall_cnt, flush_cnt);
        end
`endif
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        stim_t      t[$];
        logic [4:0] want;
        t.push_back(mk(2, 7, 1, 0, 1, 2, 0, 0, STL));   // lw $2 in EX, ID reads Rs=$2
        t.push_back(mk(2, 7, 1, 0, 0, 0, 0, 0, NRM));   // bubble in EX, ID proceeds
        t.push_back(mk(3, 9, 1, 0, 1, 9, 0, 0, STL));   // hazard through Rt
        t.push_back(mk(3, 9, 1, 0, 0, 0, 0, 0, NRM));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load_use[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_hazard();
        stim_t      t[$];
        logic [4:0] want;
        t.push_back(mk(0, 4, 1, 0, 1, 0, 0, 0, NRM));   // lw $0, ID reads $0
        t.push_back(mk(1, 5, 0, 0, 1, 5, 0, 0, NRM));   // Rt match but UsesRt=0
        t.push_back(mk(4, 8, 1, 0, 1, 6, 0, 0, NRM));   // unrelated registers
        t.push_back(mk(4, 8, 1, 1, 0, 0, 0, 0, NRM));   // HI/LO reader, MDU idle
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL no_hazard[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mdu();
        stim_t      t[$];
        logic [4:0] want;
        t.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0, NRM));        // mult issues
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));  // mfhi held x3
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, NRM));        // released
        t.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0, NRM));        // second mult
        t.push_back(mk(6, 7, 1, 0, 0, 0, 0, 0, NRM | BSY));  // non-HI/LO proceeds
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, NRM));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mdu_hold[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t      t[$];
        logic [4:0] want;
        t.push_back(mk(2, 3, 1, 0, 1, 2, 0, 1, FLS));        // branch beats load-use
        t.push_back(mk(5, 6, 1, 0, 0, 0, 0, 0, NRM));
        t.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0, NRM));        // mult issues
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, FLS | BSY));  // flush while busy
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));  // counter kept running
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, NRM));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL branch[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t      t[$];
        logic [4:0] want;
        t.push_back(mk(2, 7, 1, 0, 1, 2, 0, 0, STL));        // load-use
        t.push_back(mk(2, 7, 1, 0, 0, 0, 0, 0, NRM));
        t.push_back(mk(8, 4, 1, 0, 1, 4, 0, 0, STL));        // next load-use at once
        t.push_back(mk(8, 4, 1, 0, 0, 0, 1, 0, NRM));        // mult issues
        t.push_back(mk(9, 3, 1, 0, 1, 9, 0, 0, STL | BSY));  // load-use during MDU
        t.push_back(mk(9, 3, 1, 0, 0, 0, 0, 0, NRM | BSY));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM | BSY));
        t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mdu();
        stim_t      t[$];
        logic [4:0] want;
        t.push_back(mk(1, 2, 1, 0, 0, 0, 1, 0, NRM));        // mult issues
        t.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));  // cnt=3
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_mdu[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, STL | BSY));        // cnt=2, still held
        #1;
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_mid_mdu_pre: got %b want %b", got, want);
        end
        rst_n = 1'b0;
        exp_q.push_back(NRM);
        #1;
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_mid_mdu_async: got %b want %b", got, want);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        drive(mk(0, 0, 0, 1, 0, 0, 0, 0, NRM));              // count was discarded
        @(negedge clk);
        want = exp_q.pop_front();
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_mid_mdu_after: got %b want %b", got, want);
        end
        @(posedge clk); #1;
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic test_perf_cnt();
        stim_t      t[$];
        logic [4:0] want;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        t.push_back(mk(2, 7, 1, 0, 1, 2, 0, 0, STL));
        t.push_back(mk(2, 7, 1, 0, 0, 0, 0, 0, NRM));
        t.push_back(mk(3, 7, 1, 0, 1, 3, 0, 0, STL));
        t.push_back(mk(3, 7, 1, 0, 0, 0, 0, 0, NRM));
        t.push_back(mk(3, 7, 1, 0, 1, 3, 0, 1, FLS));
        t.push_back(mk(4, 7, 0, 0, 1, 7, 0, 0, NRM));
        t.push_back(mk(5, 6, 1, 0, 1, 6, 0, 0, STL));
        t.push_back(mk(5, 6, 1, 0, 0, 0, 0, 1, FLS));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = exp_q.pop_front();
            n_tests++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL perf_outputs[%0d]: got %b want %b", i, got, want);
            end
            @(posedge clk); #1;
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM));
        #1;
        void'(exp_q.pop_front());
        n_tests++;
        if (load_stall_cnt !== 32'd3 || flush_cnt !== 32'd2 || mdu_stall_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_counts: got load=%0d flush=%0d mdu=%0d want 3/2/0", load_stall_cnt, flush_cnt, mdu_stall_cnt);
        end
        for (int k = 0; k < 2; k++) begin
            drive(mk(2, 7, 1, 0, 1, 2, 0, 0, STL));
            @(posedge clk); #1;
            void'(exp_q.pop_front());
        end
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, NRM));
        #1;
        void'(exp_q.pop_front());
        n_tests++;
        if (load_stall_cnt !== 32'd5 || sat_load_cnt !== 2'd3 || sat_flush_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL perf_saturate: got load=%0d sat_load=%0d sat_flush=%0d want 5/3/2", load_stall_cnt, sat_load_cnt, sat_flush_cnt);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_mdu();
        test_branch();
        test_back_to_back();
        test_reset_mid_mdu();
`ifdef HAZ_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
